cnn_result_streamer: RTL
========================

Name: cnn_result_streamer

Overview:
Output-side reader for the CNN accelerator. It snapshots the 3x3 pooled result (9 x 16-bit) on a start pulse and sends it to the RISC-V side as a valid/ready stream, one element per beat in row-major order. It sits between the combinational accelerator output and the core's load/DMA interface, so the core never samples the combinational result directly.

Parameters:
DATA_W, 16, element width in bits
NUM_ELEMS, 9, elements per result map (3x3)
IDX_W, 4, width of the element index, ceil(log2(NUM_ELEMS+1))

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to capture and stream the current result
result_flat  input  NUM_ELEMS*DATA_W  accelerator output; element i at [i*DATA_W +: DATA_W], row-major
busy  output  1  high from capture until the final beat is accepted
m_valid  output  1  stream beat valid
m_ready  input  1  sink ready
m_data  output  DATA_W  element value
m_index  output  IDX_W  element index 0..NUM_ELEMS-1
m_last  output  1  high on the final beat
done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (asynchronous, active-high; all outputs forced low immediately, including mid-transfer):
  - state=IDLE; busy=0, m_valid=0, m_last=0, done=0.
  - m_data=0, m_index=0.
  - Capture buffer cleared to 0.
- States:
  - IDLE: start=1 -> copy all of result_flat into the capture buffer on that edge; index=0; go to SEND. start=0 -> stay in IDLE.
  - SEND: m_valid=1; m_data=buf[index]; m_index=index; m_last=(index==NUM_ELEMS-1).
    - On m_valid&&m_ready with index<NUM_ELEMS-1 -> index+1.
    - On the handshake of the last beat -> IDLE; done=1 for exactly the next cycle.
- Latency: first beat is valid in the cycle after start is sampled. With m_ready held at 1, a transfer takes NUM_ELEMS beats on consecutive cycles.
- Back-to-back transfers: start may be asserted in the cycle done is high, since state is already IDLE. Minimum spacing between transfers is NUM_ELEMS+1 cycles.
- Stream rules:
  - While m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable.
  - m_valid never drops before its handshake.
  - The sink may assert m_ready before m_valid.
- busy=1 in SEND, 0 otherwise. start while busy is ignored; the capture buffer is not modified.
- result_flat is sampled only on the accepted-start edge. Later changes to it do not affect the transfer in progress.
- No arithmetic on the data; elements pass through bit-exact.
- Index never exceeds NUM_ELEMS-1 and never wraps.

Optional Feature:
Macro: CNN_RESULT_CHECKSUM_EN.
- Defined:
  - After element NUM_ELEMS-1 is accepted, one extra beat is sent with m_index=NUM_ELEMS.
  - Its m_data is the modulo-2^DATA_W sum of all captured elements.
  - m_last moves from the last element to this checksum beat; done fires after the checksum beat is accepted.
  - The sum is computed incrementally at each element handshake. It is cleared at capture and on reset.
- Not defined: exactly NUM_ELEMS beats per transfer; no checksum register exists.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W=16, FMAP_IN_DIM=6, FMAP_OUT_DIM=3, NUM_OUT_ELEMS=FMAP_OUT_DIM*FMAP_OUT_DIM.
  - State enum type: IDLE, SEND.
- Sub-module: none required. The capture buffer plus element mux is small enough to remain inline; a separate cnn_result_buffer is optional.

Test Plan:
- Basic transfer: result_flat elements = 1..9, start pulse, m_ready=1 -> beats m_data 1..9, m_index 0..8 on consecutive cycles, m_last only on index 8, done one cycle after beat 8.
- Backpressure: m_ready toggles 1,0,0,1,... -> every beat stable while stalled, no duplicates or drops, order 1..9.
- Capture isolation: change result_flat to all 0xFFFF one cycle after start -> streamed data is still the original values.
- Ignored start: pulse start at beat 4 of a transfer -> no restart, busy stays 1, data unaffected. Start in the done cycle -> new transfer begins next cycle.
- Reset mid-transfer: assert rst during beat 5 -> m_valid, busy and done drop low asynchronously. After release, a fresh start streams from index 0.
- Checksum (CNN_RESULT_CHECKSUM_EN): elements 0x8000,0x8000,1,0,... -> 10th beat m_index=9, m_data=0x0001, m_last only on that beat.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and types shared across the CNN accelerator blocks.
package cnn_pkg;

    localparam int DATA_W        = 16;
    localparam int FMAP_IN_DIM   = 6;
    localparam int FMAP_OUT_DIM  = 3;
    localparam int NUM_OUT_ELEMS = FMAP_OUT_DIM * FMAP_OUT_DIM;

    // Result streamer control states.
    typedef enum logic {
        IDLE,
        SEND
    } stream_state_e;

endpackage

// File: rtl/cnn_result_streamer.sv
// cnn_result_streamer: snapshots the pooled CNN result on a start pulse and
// streams it element by element (row-major) over a valid/ready interface.
// Optional build macro CNN_RESULT_CHECKSUM_EN appends one checksum beat
// (modulo-2^DATA_W sum of all elements) with m_index = NUM_ELEMS.
module cnn_result_streamer #(
    parameter int DATA_W    = cnn_pkg::DATA_W,
    parameter int NUM_ELEMS = cnn_pkg::NUM_OUT_ELEMS,
    parameter int IDX_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_ELEMS*DATA_W-1:0] result_flat,
    output logic                        busy,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic [IDX_W-1:0]            m_index,
    output logic                        m_last,
    output logic                        done
);

    import cnn_pkg::*;

`ifdef CNN_RESULT_CHECKSUM_EN
    // The checksum rides as one extra beat after the last element.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);
`endif

    stream_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] buf_q [NUM_ELEMS];
    logic [DATA_W-1:0] buf_d [NUM_ELEMS];
    logic [DATA_W-1:0] elem;
    logic              fire;

    assign fire = (state_q == SEND) && m_ready;

`ifdef CNN_RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    // Next-state: capture on an accepted start, advance the index on each handshake.
    always_comb begin
        // NOTE: every signal driven here gets its default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_ELEMS; i++) begin
                        buf_d[i] = result_flat[i*DATA_W +: DATA_W];
                    end
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Element mux: captured element for data beats, running sum for the checksum beat.
    always_comb begin
        elem = '0;
        if (idx_q < IDX_W'(NUM_ELEMS)) begin
            elem = buf_q[idx_q];
        end
`ifdef CNN_RESULT_CHECKSUM_EN
        else begin
            elem = sum_q;
        end
`endif
    end

`ifdef CNN_RESULT_CHECKSUM_EN
    // Running checksum: cleared at capture, accumulates each accepted data element.
    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = '0;
        end else if (fire && idx_q < IDX_W'(NUM_ELEMS)) begin
            sum_d = sum_q + elem;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Control state and capture buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the capture buffer is only a few words, so it is cleared on reset with the control state.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            buf_q   <= buf_d;
        end
    end

    // Stream outputs decode straight from registered state, so reset clears them at once.
    assign busy    = (state_q == SEND);
    assign m_valid = (state_q == SEND);
    assign m_data  = (state_q == SEND) ? elem : '0;
    assign m_index = (state_q == SEND) ? idx_q : '0;
    assign m_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign done    = done_q;

endmodule
